// File: rtl/activity_blink.sv
// activity_blink: turns single-cycle event strobes into visible LED blinks.
// Each accepted event gives one ON period of 2**ON_WIDTH cycles followed by
// an OFF gap of 2**OFF_WIDTH cycles. Events that arrive during a blink are
// remembered and replayed as further blinks.
// Optional feature macro: ACTIVITY_BLINK_QUEUE_EN. When it is defined, the
// pending store is a PEND_WIDTH-bit saturating counter and overflow is
// reported on dropped. Otherwise, the store is a single coalescing flag and
// dropped is held at 0.
// The strobe input is named evt because "event" is a reserved word.
module activity_blink #(
  parameter int ON_WIDTH   = 20,
  parameter int OFF_WIDTH  = 20,
  parameter int PEND_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  output logic led,
  output logic busy,
  output logic dropped
);

  // One down-counter times both phases, so it is as wide as the longer phase.
  localparam int CNT_WIDTH = (ON_WIDTH > OFF_WIDTH) ? ON_WIDTH : OFF_WIDTH;

`ifdef ACTIVITY_BLINK_QUEUE_EN
  localparam int PW = PEND_WIDTH;
`else
  // A single flag is enough when pending events coalesce; PEND_WIDTH has no effect.
  localparam int PW = (PEND_WIDTH > 0) ? 1 : 1;
`endif

  localparam logic [CNT_WIDTH-1:0] ON_RELOAD  = CNT_WIDTH'((64'd1 << ON_WIDTH) - 64'd1);
  localparam logic [CNT_WIDTH-1:0] OFF_RELOAD = CNT_WIDTH'((64'd1 << OFF_WIDTH) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   count, count_next;
  logic [PW-1:0]          pending, pending_next;
  logic                   inc;
  logic                   consume;
  logic                   drop;

  // Phase sequencing: decides the next state and counter value, and decides
  // whether this cycle adds to or takes from the pending store.
  always_comb begin
    state_next = state;
    count_next = count;
    inc        = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        // An event in IDLE starts a blink directly. It never goes through pending.
        if (evt) begin
          state_next = ON;
          count_next = ON_RELOAD;
        end
      end
      ON: begin
        inc = evt;
        if (count != '0) begin
          count_next = count - CNT_WIDTH'(1);
        end else begin
          state_next = GAP;
          count_next = OFF_RELOAD;
        end
      end
      GAP: begin
        if (count != '0) begin
          inc        = evt;
          count_next = count - CNT_WIDTH'(1);
        end else if ((pending != '0) || evt) begin
          state_next = ON;
          count_next = ON_RELOAD;
          // A stored event is consumed first; a same-cycle event then replaces it.
          // With nothing stored, the same-cycle event itself is consumed.
          if (pending != '0) begin
            consume = 1'b1;
            inc     = evt;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Pending store: saturating add/subtract. If an add and a subtract happen together, they cancel.
  always_comb begin
    pending_next = pending;
    drop         = 1'b0;
    if (inc && !consume) begin
      if (&pending) begin
`ifdef ACTIVITY_BLINK_QUEUE_EN
        drop = 1'b1;
`endif
      end else begin
        pending_next = pending + PW'(1);
      end
    end else if (consume && !inc) begin
      pending_next = pending - PW'(1);
    end
  end

  // State, counter, pending and registered outputs. Reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      pending <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      pending <= pending_next;
      led     <= (state_next == ON);
      busy    <= (state_next != IDLE);
      dropped <= drop;
    end
  end

endmodule
